// File: rtl/utpu_pkg.sv
// Shared types and constants for the systolic-array control slice.
package utpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } seq_state_t;

    localparam int DEFAULT_ARRAY_DIM = 4;
    localparam int SRAM_RD_LAT       = 1;

endpackage

// File: rtl/systolic_array_sequencer.sv
// Sequences a weight-stationary PE array through preload, stream and drain,
// driving SRAM read strobes, array enables and per-column result valids.
module systolic_array_sequencer
    import utpu_pkg::*;
#(
    parameter int ARRAY_DIM     = DEFAULT_ARRAY_DIM,
    parameter int ROW_CNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ROW_CNT_WIDTH-1:0]     num_rows,
    input  logic                         reuse_weights,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         w_rd_en,
    output logic [$clog2(ARRAY_DIM)-1:0] w_rd_addr,
    output logic                         a_rd_en,
    output logic [ROW_CNT_WIDTH-1:0]     a_rd_addr,
    output logic                         load_en,
    output logic                         compute,
    output logic [ARRAY_DIM-1:0]         out_col_valid
);

    localparam int AW = $clog2(ARRAY_DIM);
    localparam int CW = $clog2((1 << ROW_CNT_WIDTH) + 2 * ARRAY_DIM);

    seq_state_t                state, nstate;
    logic [CW-1:0]             cyc, ncyc;
    logic [ROW_CNT_WIDTH-1:0]  m_q;
    logic [SRAM_RD_LAT-1:0]    w_dly;
    logic [ARRAY_DIM-1:0]      ocv_nxt;
    logic [CW-1:0]             m_ext;
    logic [CW-1:0]             last_cyc;
    logic                      active;
    logic                      kill;
    logic                      compute_nxt;

    assign m_ext    = CW'(m_q);
    assign last_cyc = m_ext + CW'(2 * ARRAY_DIM - 1);
    assign active   = (state == STREAM) || (state == DRAIN);
    assign kill     = abort && (state != IDLE);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign load_en  = w_dly[SRAM_RD_LAT-1];

    always_comb begin
        nstate    = state;
        ncyc      = cyc + CW'(1);
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        a_rd_en   = 1'b0;
        a_rd_addr = '0;
        unique case (state)
            IDLE: begin
                ncyc = '0;
                if (start) begin
                    if (num_rows == '0)
                        nstate = DONE;
                    else if (reuse_weights)
                        nstate = STREAM;
                    else
                        nstate = LOAD_W;
                end
            end
            LOAD_W: begin
                // Bottom row is fetched first so it shifts deepest.
                w_rd_en   = 1'b1;
                w_rd_addr = AW'(ARRAY_DIM - 1) - cyc[AW-1:0];
                if (cyc == CW'(ARRAY_DIM - 1)) begin
                    nstate = STREAM;
                    ncyc   = '0;
                end
            end
            STREAM: begin
                a_rd_en   = 1'b1;
                a_rd_addr = cyc[ROW_CNT_WIDTH-1:0];
                if (cyc == m_ext - CW'(1))
                    nstate = DRAIN;
            end
            DRAIN: begin
                if (cyc == last_cyc)
                    nstate = DONE;
            end
            DONE: begin
                nstate = IDLE;
                ncyc   = '0;
            end
            default: begin
                nstate = IDLE;
                ncyc   = '0;
            end
        endcase
        if (kill) begin
            nstate = IDLE;
            ncyc   = '0;
        end
    end

    // Registered enables look at the current cyc, so they land one count later.
    always_comb begin
        compute_nxt = active && (cyc < last_cyc) && !kill;
    end

    for (genvar j = 0; j < ARRAY_DIM; j++) begin : g_col
        always_comb begin
            ocv_nxt[j] = active && !kill
                && (cyc >= CW'(ARRAY_DIM + j))
                && (cyc <  CW'(ARRAY_DIM + j) + m_ext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cyc           <= '0;
            m_q           <= '0;
            w_dly         <= '0;
            compute       <= 1'b0;
            out_col_valid <= '0;
        end else begin
            state         <= nstate;
            cyc           <= ncyc;
            compute       <= compute_nxt;
            out_col_valid <= ocv_nxt;
            if (state == IDLE && start)
                m_q <= num_rows;
            w_dly[0] <= w_rd_en && !kill;
            for (int i = 1; i < SRAM_RD_LAT; i++)
                w_dly[i] <= w_dly[i-1] && !kill;
        end
    end

endmodule
